// File: rtl/led_pattern_gen_pkg.sv
// Shared encodings for the LED pattern generator: display modes, bounce
// direction and the per-bit initial pattern of each mode.
package led_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ModeBlink     = 2'b00,
    ModeAlternate = 2'b01,
    ModeChase     = 2'b10,
    ModeBounce    = 2'b11
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  // Value of LED bit idx when a mode is (re)loaded.
  function automatic logic init_bit(mode_e mode, int unsigned idx);
    logic bit_val;
    case (mode)
      ModeBlink:     bit_val = 1'b1;
      ModeAlternate: bit_val = ((idx % 2) == 0);
      default:       bit_val = (idx == 0);
    endcase
    return bit_val;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts enabled cycles and flags the terminal count of the
// current step period (TICK_CYCLES >> Speed).
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic [1:0] Speed,
  input  logic       Clear,
  output logic       Terminal
);

  localparam int unsigned CntW = $clog2(TICK_CYCLES);

  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     limit;
  logic            at_limit;

  // Terminal uses >= so a Speed change that leaves the count past the new
  // limit still produces exactly one step on the next enabled edge.
  always_comb begin
    limit    = (TICK_CYCLES >> Speed) - 32'd1;
    at_limit = (32'(count_q) >= limit);
    Terminal = Enable && !Clear && at_limit;
    if (Clear || Terminal) begin
      count_d = '0;
    end else if (Enable) begin
      count_d = count_q + CntW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: blink, alternate, chase and bounce patterns stepped
// by a prescaled tick. LED and Tick are registered; a mode change reloads the
// pattern and restarts the prescaler.
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 18,
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic                CLOCK_50,
  input  logic                Resetn,
  input  logic                Enable,
  input  logic [1:0]          Mode,
  input  logic [1:0]          Speed,
  output logic [NUM_LEDS-1:0] LED,
  output logic                Tick
);

  mode_e               mode_in, mode_q;
  dir_e                dir_q, step_dir;
  logic [NUM_LEDS-1:0] led_q, init_led, step_led, shifted;
  logic                mode_chg, terminal, tick_q;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .CLOCK_50(CLOCK_50),
    .Resetn  (Resetn),
    .Enable  (Enable),
    .Speed   (Speed),
    .Clear   (mode_chg),
    .Terminal(terminal)
  );

  // Mode change detection and the initial pattern of the requested mode.
  always_comb begin
    mode_in  = mode_e'(Mode);
    mode_chg = (mode_in != mode_q);
    init_led = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      init_led[i] = init_bit(mode_in, i);
    end
  end

  // Next pattern value for a step in the current mode.
  always_comb begin
    step_led = led_q;
    step_dir = dir_q;
    shifted  = '0;
    case (mode_q)
      ModeBlink, ModeAlternate: step_led = ~led_q;
      // With one LED the rotate degenerates to holding the value.
      ModeChase: step_led = (led_q << 1) | (led_q >> (NUM_LEDS - 1));
      ModeBounce: begin
        if (NUM_LEDS > 1) begin
          if (dir_q == DirUp) begin
            shifted = led_q << 1;
            if (shifted[NUM_LEDS-1]) step_dir = DirDown;
          end else begin
            shifted = led_q >> 1;
            if (shifted[0]) step_dir = DirUp;
          end
          step_led = shifted;
        end
      end
      default: ;
    endcase
  end

  // Pattern state; a mode change outranks a coincident terminal count.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      mode_q <= ModeBlink;
      dir_q  <= DirUp;
      led_q  <= '1;
      tick_q <= 1'b0;
    end else if (mode_chg) begin
      mode_q <= mode_in;
      dir_q  <= DirUp;
      led_q  <= init_led;
      tick_q <= 1'b0;
    end else if (terminal) begin
      dir_q  <= step_dir;
      led_q  <= step_led;
      tick_q <= 1'b1;
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign LED  = led_q;
  assign Tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen (NUM_LEDS=8, TICK_CYCLES=10): directed scenarios
// followed by randomized stimulus, all checked against a step-index model.
module tb_led_pattern_gen;

  localparam int unsigned N  = 8;
  localparam int unsigned TC = 10;

  logic         clk   = 1'b0;
  logic         rstn  = 1'b0;
  logic         en    = 1'b1;
  logic [1:0]   mode  = 2'd0;
  logic [1:0]   speed = 2'd0;
  logic [N-1:0] led;
  logic         tick;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state: mode, enabled-cycle count, steps taken since the mode load.
  int m_mode  = 0;
  int m_count = 0;
  int m_k     = 0;
  bit m_tick  = 1'b0;

  logic [7:0] bounce_seq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_LEDS   (N),
    .TICK_CYCLES(TC)
  ) dut (
    .CLOCK_50(clk),
    .Resetn  (rstn),
    .Enable  (en),
    .Mode    (mode),
    .Speed   (speed),
    .LED     (led),
    .Tick    (tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pattern after k steps in mode m, from the closed-form description.
  function automatic logic [N-1:0] model_led(int m, int k);
    logic [N-1:0] one = 1;
    logic [N-1:0] v   = '0;
    int p;
    case (m)
      0: v = (k % 2 == 0) ? '1 : '0;
      1: begin
        for (int i = 0; i < int'(N); i++) v[i] = ((i % 2) == (k % 2));
      end
      2: v = one << (k % N);
      default: begin
        p = k % (2 * (N - 1));
        v = one << ((p < int'(N)) ? p : (2 * (N - 1) - p));
      end
    endcase
    return v;
  endfunction

  task automatic model_edge();
    int period;
    period = int'(TC >> speed);
    if (!rstn) begin
      m_mode = 0; m_count = 0; m_k = 0; m_tick = 1'b0;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_count = 0; m_k = 0; m_tick = 1'b0;
    end else if (en && m_count >= period - 1) begin
      m_count = 0; m_k++; m_tick = 1'b1;
    end else begin
      m_tick = 1'b0;
      if (en) m_count++;
    end
  endtask

  // One clock: inputs are stable across the rising edge, outputs sampled on
  // the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("led", 32'(led), 32'(model_led(m_mode, m_k)));
    check_eq("tick", 32'(tick), 32'(m_tick));
  endtask

  initial begin
    // Reset state.
    repeat (3) step();
    check_eq("rst_led", 32'(led), 32'hFF);
    check_eq("rst_tick", 32'(tick), 32'h0);

    // Blink: toggles at edges 10 and 20 after release.
    rstn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) begin
        check_eq("blink_e10_led", 32'(led), 32'h00);
        check_eq("blink_e10_tick", 32'(tick), 32'h1);
      end
      if (i == 20) begin
        check_eq("blink_e20_led", 32'(led), 32'hFF);
        check_eq("blink_e20_tick", 32'(tick), 32'h1);
      end
    end

    // Bounce sequence including both end reversals.
    mode = 2'b11;
    step();
    check_eq("bounce_load", 32'(led), 32'h01);
    for (int j = 1; j < 16; j++) begin
      repeat (10) step();
      check_eq("bounce_seq", 32'(led), 32'(bounce_seq[j]));
      check_eq("bounce_tick", 32'(tick), 32'h1);
    end

    // Mode change coincident with terminal count wins over the step.
    mode = 2'b01;
    step();
    repeat (9) step();
    mode = 2'b10;
    step();
    check_eq("chg_term_led", 32'(led), 32'h01);
    check_eq("chg_term_tick", 32'(tick), 32'h0);
    repeat (9) step();
    check_eq("chg_term_quiet", 32'(tick), 32'h0);
    step();
    check_eq("chg_term_next", 32'(led), 32'h02);
    check_eq("chg_term_ntick", 32'(tick), 32'h1);

    // Enable low for 7 cycles at count 4; step lands 6 cycles after re-enable.
    mode = 2'b00;
    step();
    repeat (4) step();
    en = 1'b0;
    repeat (7) step();
    check_eq("frz_led", 32'(led), 32'hFF);
    check_eq("frz_tick", 32'(tick), 32'h0);
    en = 1'b1;
    repeat (5) step();
    check_eq("frz_pre", 32'(tick), 32'h0);
    step();
    check_eq("frz_step_led", 32'(led), 32'h00);
    check_eq("frz_step_tick", 32'(tick), 32'h1);

    // Reset mid-bounce while heading down.
    mode = 2'b11;
    step();
    repeat (80) step();
    repeat (3) step();
    rstn = 1'b0;
    #1;
    check_eq("async_rst_led", 32'(led), 32'hFF);
    step();
    rstn = 1'b1;
    step();
    check_eq("rel_load_led", 32'(led), 32'h01);
    check_eq("rel_load_tick", 32'(tick), 32'h0);
    repeat (9) step();
    step();
    check_eq("rel_first_step", 32'(led), 32'h02);

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) speed = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 7) != 0);
      if (!rstn) begin
        if ($urandom_range(0, 1) == 0) rstn = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        rstn = 1'b0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter NUM_LEDS, default 18, width of the LED output vector (legal range 1 to 32).
REQ-002 Parameter TICK_CYCLES, default 50_000_000, clock cycles per pattern step at Speed=0 (minimum 8).
REQ-003 Port CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-004 Port Resetn  input  1  reset, asynchronous, active-low.
REQ-005 Port Enable  input  1  1 = run; 0 = freeze counter and pattern.
REQ-006 Port Mode  input  2  00 BLINK, 01 ALTERNATE, 10 CHASE, 11 BOUNCE.
REQ-007 Port Speed  input  2  step period = TICK_CYCLES >> Speed (1x, 2x, 4x, 8x faster).
REQ-008 Port LED  output  NUM_LEDS  current pattern, registered.
REQ-009 Port Tick  output  1  one-cycle pulse, registered, asserted in the cycle LED takes a new step value.

Function
REQ-010 The prescaler SHALL use a counter of width $clog2(TICK_CYCLES), clear it to 0 at terminal, and treat Count >= (TICK_CYCLES >> Speed) - 1 as terminal.
REQ-011 When Enable=1 and the count is not terminal, Count SHALL increment by 1, and Tick SHALL be 0.
REQ-012 When Enable=1 and the count is terminal, the next edge SHALL set Count to 0, Tick to 1, and LED to the next step value.
REQ-013 When Enable=0, Count, LED and direction SHALL hold, and Tick SHALL be 0.
REQ-014 Initial patterns: BLINK all ones; ALTERNATE bit0=1 and alternating (0101...01); CHASE and BOUNCE bit0 only.
REQ-015 BLINK step: LED <= ~LED (all on / all off).
REQ-016 ALTERNATE step: LED <= ~LED (checkerboard inverts).
REQ-017 CHASE step: rotate left by one; MSB wraps to bit0.
REQ-018 BOUNCE step: shift toward MSB while Dir=up, toward bit0 while Dir=down.
REQ-019 BOUNCE reversal: arriving at the MSB sets Dir=down; arriving at bit0 sets Dir=up; the end LED is shown for exactly one step (no double dwell).
REQ-020 When NUM_LEDS=1: CHASE and BOUNCE SHALL hold LED=1; BLINK and ALTERNATE SHALL toggle.
REQ-021 Mode is registered internally as ModeReg. When Mode != ModeReg, the next edge SHALL:
  - set ModeReg to Mode;
  - clear Count to 0;
  - load LED with the initial pattern of the new mode;
  - set Dir=up and Tick=0.
  This applies regardless of Enable, and mode change has priority over a coincident terminal count.
REQ-022 A Speed change SHALL take effect on the next comparison without clearing Count. If Count is already past the new terminal, the next enabled edge is a terminal step.
REQ-023 Exactly one step SHALL occur per terminal event; LED never skips or repeats a step.

Reset
REQ-024 While Resetn=0, the block SHALL hold: LED all ones, Tick=0, Count=0, ModeReg=BLINK, Dir=up.
REQ-025 Reset asserted mid-step SHALL discard the partial count immediately; after release, the first step occurs TICK_CYCLES>>Speed enabled cycles later.
REQ-026 If Mode != BLINK at reset release, REQ-021 SHALL apply on the first edge after release.

Structure
REQ-027 A shared package SHALL hold the Mode encodings (BLINK, ALTERNATE, CHASE, BOUNCE) and the Dir encoding.
REQ-028 The prescaler SHALL be a sub-module tick_gen, with parameter TICK_CYCLES, inputs CLOCK_50, Resetn, Enable, Speed and Clear, and output terminal pulse.
REQ-029 Pattern sequencing SHALL be in led_pattern_gen; there SHALL be no combinational path from any input to LED or Tick.

Verification (NUM_LEDS=8, TICK_CYCLES=10)
REQ-030 Reset, Mode=00, Speed=0, Enable=1 -> LED=FF; at edge 10 after release LED=00 with Tick=1; at edge 20 LED=FF.
REQ-031 Mode=10, Speed=1 -> LED=01 after reload, then 02, 04, ... 80, 01; one step per 5 cycles; Tick high 1 cycle per step.
REQ-032 Mode=11 -> LED sequence 01, 02, 04, 08, 10, 20, 40, 80, 40, 20, 10, 08, 04, 02, 01, 02.
REQ-033 Mode changed 01->10 in the same cycle as a terminal count -> next LED=01 with Tick=0 and Count=0; the next step follows 10 cycles later.
REQ-034 Enable=0 for 7 cycles at Count=4 -> LED and Tick frozen; after re-enable, the step occurs 6 cycles later.
REQ-035 Resetn pulsed low mid-BOUNCE with Dir=down, Mode=11 held -> LED=FF during reset; first edge after release gives LED=01 and Dir=up; the next step occurs 10 cycles later and gives LED=02.
